// File: rtl/div_unit.sv
// Signed restoring divider: quotient to DivLo, remainder to DivHi, truncating toward zero.
// Latency: DATA_W+1 cycles from the DivCtrl edge to DivDone; DivCtrl is ignored while DivBusy.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              DivCtrl,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] DivHi,
    output logic [DATA_W-1:0] DivLo,
    output logic              DivBusy,
    output logic              DivDone,
    output logic              DivZero
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                zero_q, zero_d;

    // quo_q starts as |A| and shifts out dividend bits while quotient bits shift in.
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     rem_sub;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        zero_d  = 1'b0;
        rem_sh  = {rem_q, quo_q[DATA_W-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (DivCtrl) begin
                    if (B == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        quo_d   = A[DATA_W-1] ? -A : A;
                        dvs_d   = B[DATA_W-1] ? -B : B;
                        qneg_d  = A[DATA_W-1] ^ B[DATA_W-1];
                        rneg_d  = A[DATA_W-1];
                        rem_d   = '0;
                        cnt_d   = CNT_W'(DATA_W - 1);
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (rem_sub[DATA_W]) begin
                    rem_d = rem_sh[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end else begin
                    rem_d = rem_sub[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                lo_d    = qneg_q ? -quo_q : quo_q;
                hi_d    = rneg_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
        end
    end

    assign DivHi   = hi_q;
    assign DivLo   = lo_q;
    assign DivBusy = busy_q;
    assign DivDone = done_q;
    assign DivZero = zero_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a latency/arithmetic reference model checked every cycle,
// plus literal expectations on the quotient/remainder of each directed case.
module tb_div_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         DivCtrl = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] DivHi, DivLo;
    logic         DivBusy, DivDone, DivZero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    div_unit #(.DATA_W(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .DivCtrl(DivCtrl),
        .A      (A),
        .B      (B),
        .DivHi  (DivHi),
        .DivLo  (DivLo),
        .DivBusy(DivBusy),
        .DivDone(DivDone),
        .DivZero(DivZero)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: 64-bit signed divide, truncated back to W bits.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
    endfunction

    // Model: a started division finishes W+1 edges later; busy until then.
    logic [W-1:0] m_hi = '0, m_lo = '0, p_q = '0, p_r = '0;
    logic         m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b0;
    int           m_left = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_zero = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            m_zero = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_hi   = p_r;
                    m_lo   = p_q;
                end
            end else if (DivCtrl) begin
                if (B == '0) begin
                    m_zero = 1'b1;
                end else begin
                    ref_div(A, B, p_q, p_r);
                    m_left = W + 1;
                end
            end
            m_busy = (m_left > 0);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_busy", W'(DivBusy), W'(m_busy));
            check("cyc_done", W'(DivDone), W'(m_done));
            check("cyc_zero", W'(DivZero), W'(m_zero));
            check("cyc_hi", DivHi, m_hi);
            check("cyc_lo", DivLo, m_lo);
        end
    end

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clock); #1;
        A = a; B = b; DivCtrl = 1'b1;
        @(posedge clock); #1;
        DivCtrl = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic wait_done(input string nm, input logic [W-1:0] elo, input logic [W-1:0] ehi);
        bit seen = 1'b0;
        for (int i = 0; i < 45 && !seen; i++) begin
            @(negedge clock);
            if (DivDone) seen = 1'b1;
        end
        check({nm, "_done_seen"}, W'(seen), W'(1));
        check({nm, "_lo"}, DivLo, elo);
        check({nm, "_hi"}, DivHi, ehi);
    endtask

    initial begin
        int cnt;
        #3 reset = 1'b0;
        @(negedge clock);
        chk_en = 1'b1;
        check("rst_lo", DivLo, 32'h0);
        check("rst_busy", W'(DivBusy), W'(0));
        @(posedge clock); #1 reset = 1'b1;

        start(32'd7, 32'd2);
        wait_done("p7_2", 32'd3, 32'd1);
        start(32'hFFFF_FFF9, 32'd2);
        wait_done("m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        start(32'd7, 32'hFFFF_FFFE);
        wait_done("p7_m2", 32'hFFFF_FFFD, 32'd1);
        start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("min_m1", 32'h8000_0000, 32'h0);

        // Divide by zero: pulse only, result untouched.
        cnt = 0;
        @(posedge clock); #1;
        A = 32'd5; B = 32'd0; DivCtrl = 1'b1;
        @(posedge clock); #1;
        DivCtrl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (DivZero) cnt++;
        end
        check("dz_pulses", W'(cnt), W'(1));
        check("dz_lo_kept", DivLo, 32'h8000_0000);

        start(32'd0, 32'd5);
        wait_done("z_5", 32'd0, 32'd0);

        // Second request mid-division must be ignored.
        start(32'd100, 32'd7);
        repeat (4) @(posedge clock);
        #1 A = 32'd1; B = 32'd1; DivCtrl = 1'b1;
        @(posedge clock); #1 DivCtrl = 1'b0;
        wait_done("p100_7", 32'd14, 32'd2);

        // Start in the cycle DivDone is high.
        A = 32'hFFFF_FF9C; B = 32'hFFFF_FFF9; DivCtrl = 1'b1;
        @(posedge clock); #1 DivCtrl = 1'b0;
        wait_done("m100_m7", 32'd14, 32'hFFFF_FFFE);

        // Reset mid-division aborts it.
        start(32'd50, 32'd6);
        repeat (9) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("mid_rst_busy", W'(DivBusy), W'(0));
        check("mid_rst_hi", DivHi, 32'h0);
        @(posedge clock); #1 reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (DivDone) cnt++;
        end
        check("abort_no_done", W'(cnt), W'(0));
        start(32'd9, 32'd3);
        wait_done("p9_3", 32'd3, 32'd0);

        repeat (2) @(negedge clock);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
